// File: rtl/uart_frame_loader_sync_if.sv
// Byte-stream input and framebuffer write-port bundle for uart_frame_loader_sync.
`timescale 1ns/1ps
interface uart_frame_loader_sync_if #(
   parameter int unsigned ADDR_W   = 17,
   parameter int unsigned PIX_BITS = 12
);
   logic [7:0]          rx_byte;
   logic                rx_vld;
   logic                write_buf_sys;
   logic                wr_en;
   logic [ADDR_W-1:0]   wr_addr;
   logic [PIX_BITS-1:0] wr_data;
   logic                wr_bank;
   logic                swap_req;
   logic                frame_err;
   logic [1:0]          err_code;
   logic                busy;
   logic [15:0]         frames_ok;
   logic [15:0]         frames_bad;

   modport master (
      output rx_byte, rx_vld, write_buf_sys,
      input  wr_en, wr_addr, wr_data, wr_bank, swap_req, frame_err,
             err_code, busy, frames_ok, frames_bad
   );

   modport slave (
      input  rx_byte, rx_vld, write_buf_sys,
      output wr_en, wr_addr, wr_data, wr_bank, swap_req, frame_err,
             err_code, busy, frames_ok, frames_bad
   );
endinterface

// File: rtl/uart_frame_loader_sync.sv
// Hunts a 2-byte sync header, writes one frame of pixels into the inactive bank,
// and requests a swap only when the trailing checksum matches.
`timescale 1ns/1ps
module uart_frame_loader_sync #(
   parameter int unsigned WIDTH       = 320,
   parameter int unsigned HEIGHT      = 240,
   parameter int unsigned PIX_BITS    = 12,
   parameter int unsigned ADDR_W      = 17,
   parameter logic [7:0]  SYNC0       = 8'hA5,
   parameter logic [7:0]  SYNC1       = 8'h5A,
   parameter int unsigned TIMEOUT_CYC = 1000000
) (
   input  logic                     clk_sys,
   input  logic                     rst_sys,
   uart_frame_loader_sync_if.slave  io
);
   localparam int unsigned BPP   = (PIX_BITS + 7) / 8;
   localparam int unsigned ASM_W = 8 * BPP;
   localparam int unsigned NPIX  = WIDTH * HEIGHT;
   localparam int unsigned CNT_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;

   typedef enum logic [1:0] {HUNT0, HUNT1, PAYLOAD, CSUM} state_e;

   state_e              state_q, state_d;
   logic [CNT_W-1:0]    idle_q, idle_d;
   logic [1:0]          idx_q, idx_d;
   logic [ASM_W-1:0]    asm_q, asm_d;
   logic [7:0]          csum_q, csum_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic                wr_en_q, wr_en_d;
   logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
   logic [PIX_BITS-1:0] wr_data_q, wr_data_d;
   logic                wr_bank_q, wr_bank_d;
   logic                swap_req_q, swap_req_d;
   logic                frame_err_q, frame_err_d;
   logic [1:0]          err_code_q, err_code_d;
   logic                busy_q, busy_d;
   logic [15:0]         frames_ok_q, frames_ok_d;
   logic [15:0]         frames_bad_q, frames_bad_d;

   always_comb begin
      state_d      = state_q;
      idle_d       = idle_q;
      idx_d        = idx_q;
      asm_d        = asm_q;
      csum_d       = csum_q;
      addr_d       = addr_q;
      wr_en_d      = 1'b0;
      wr_addr_d    = wr_addr_q;
      wr_data_d    = wr_data_q;
      wr_bank_d    = wr_bank_q;
      swap_req_d   = 1'b0;
      frame_err_d  = 1'b0;
      err_code_d   = err_code_q;
      busy_d       = busy_q;
      frames_ok_d  = frames_ok_q;
      frames_bad_d = frames_bad_q;

      // A byte arriving on the terminal idle count wins over the timeout.
      if (io.rx_vld) begin
         idle_d = '0;
         unique case (state_q)
            HUNT0: begin
               if (io.rx_byte == SYNC0) state_d = HUNT1;
            end
            HUNT1: begin
               if (io.rx_byte == SYNC1) begin
                  state_d   = PAYLOAD;
                  addr_d    = '0;
                  idx_d     = '0;
                  csum_d    = '0;
                  wr_bank_d = io.write_buf_sys;
                  busy_d    = 1'b1;
               end else if (io.rx_byte != SYNC0) begin
                  state_d = HUNT0;
               end
            end
            PAYLOAD: begin
               csum_d = csum_q + io.rx_byte;
               // Truncating the concatenation shifts the new byte in at the LSB end.
               asm_d  = ASM_W'({asm_q, io.rx_byte});
               if (idx_q == 2'(BPP - 1)) begin
                  wr_en_d   = 1'b1;
                  wr_addr_d = addr_q;
                  wr_data_d = asm_d[ASM_W-1 -: PIX_BITS];
                  addr_d    = addr_q + 1'b1;
                  idx_d     = '0;
                  if (addr_q == ADDR_W'(NPIX - 1)) state_d = CSUM;
               end else begin
                  idx_d = idx_q + 2'd1;
               end
            end
            CSUM: begin
               if (io.rx_byte == csum_q) begin
                  swap_req_d  = 1'b1;
                  frames_ok_d = frames_ok_q + 16'd1;
               end else begin
                  frame_err_d  = 1'b1;
                  err_code_d   = 2'b01;
                  frames_bad_d = frames_bad_q + 16'd1;
               end
               state_d = HUNT0;
               busy_d  = 1'b0;
            end
         endcase
      end else if (state_q != HUNT0) begin
         if (idle_q == CNT_W'(TIMEOUT_CYC - 1)) begin
            state_d = HUNT0;
            idle_d  = '0;
            busy_d  = 1'b0;
            // A stalled header is not a frame yet, so it is dropped silently.
            if (state_q != HUNT1) begin
               frame_err_d  = 1'b1;
               err_code_d   = 2'b10;
               frames_bad_d = frames_bad_q + 16'd1;
            end
         end else begin
            idle_d = idle_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk_sys or posedge rst_sys) begin
      if (rst_sys) begin
         state_q      <= HUNT0;
         idle_q       <= '0;
         idx_q        <= '0;
         asm_q        <= '0;
         csum_q       <= '0;
         addr_q       <= '0;
         wr_en_q      <= 1'b0;
         wr_addr_q    <= '0;
         wr_data_q    <= '0;
         wr_bank_q    <= 1'b0;
         swap_req_q   <= 1'b0;
         frame_err_q  <= 1'b0;
         err_code_q   <= '0;
         busy_q       <= 1'b0;
         frames_ok_q  <= '0;
         frames_bad_q <= '0;
      end else begin
         state_q      <= state_d;
         idle_q       <= idle_d;
         idx_q        <= idx_d;
         asm_q        <= asm_d;
         csum_q       <= csum_d;
         addr_q       <= addr_d;
         wr_en_q      <= wr_en_d;
         wr_addr_q    <= wr_addr_d;
         wr_data_q    <= wr_data_d;
         wr_bank_q    <= wr_bank_d;
         swap_req_q   <= swap_req_d;
         frame_err_q  <= frame_err_d;
         err_code_q   <= err_code_d;
         busy_q       <= busy_d;
         frames_ok_q  <= frames_ok_d;
         frames_bad_q <= frames_bad_d;
      end
   end

   assign io.wr_en      = wr_en_q;
   assign io.wr_addr    = wr_addr_q;
   assign io.wr_data    = wr_data_q;
   assign io.wr_bank    = wr_bank_q;
   assign io.swap_req   = swap_req_q;
   assign io.frame_err  = frame_err_q;
   assign io.err_code   = err_code_q;
   assign io.busy       = busy_q;
   assign io.frames_ok  = frames_ok_q;
   assign io.frames_bad = frames_bad_q;
endmodule

// File: tb/tb_uart_frame_loader_sync.sv
// Directed bench: 4x2x12-bit loader (timeout 50) plus 24-bit and 5-bit pixel variants.
`timescale 1ns/1ps
module tb_uart_frame_loader_sync;
   logic clk_sys = 1'b0;
   logic rst_sys = 1'b1;
   always #5 clk_sys = ~clk_sys;

   int checks   = 0;
   int failures = 0;
   logic [15:0] exp_ok  = '0;
   logic [15:0] exp_bad = '0;

   uart_frame_loader_sync_if #(.ADDR_W(3), .PIX_BITS(12)) ia ();
   uart_frame_loader_sync_if #(.ADDR_W(1), .PIX_BITS(24)) ib ();
   uart_frame_loader_sync_if #(.ADDR_W(1), .PIX_BITS(5))  ic ();

   uart_frame_loader_sync #(.WIDTH(4), .HEIGHT(2), .PIX_BITS(12), .ADDR_W(3),
      .SYNC0(8'hA5), .SYNC1(8'h5A), .TIMEOUT_CYC(50))
      dut_a (.clk_sys(clk_sys), .rst_sys(rst_sys), .io(ia.slave));
   uart_frame_loader_sync #(.WIDTH(2), .HEIGHT(1), .PIX_BITS(24), .ADDR_W(1),
      .SYNC0(8'hA5), .SYNC1(8'h5A), .TIMEOUT_CYC(50))
      dut_b (.clk_sys(clk_sys), .rst_sys(rst_sys), .io(ib.slave));
   uart_frame_loader_sync #(.WIDTH(2), .HEIGHT(1), .PIX_BITS(5), .ADDR_W(1),
      .SYNC0(8'hA5), .SYNC1(8'h5A), .TIMEOUT_CYC(50))
      dut_c (.clk_sys(clk_sys), .rst_sys(rst_sys), .io(ic.slave));

   // Payload deliberately contains A5/5A bytes; pixels and sum (0xBC) worked by hand.
   logic [7:0]  pay_a [16] = '{8'hAB, 8'hC0, 8'hA5, 8'h5A, 8'h12, 8'h3F, 8'hFF, 8'hFF,
                               8'h00, 8'h0F, 8'h5A, 8'hA5, 8'h80, 8'h10, 8'h7E, 8'hE7};
   logic [11:0] pix_a [8]  = '{12'hABC, 12'hA55, 12'h123, 12'hFFF,
                               12'h000, 12'h5AA, 12'h801, 12'h7EE};

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic send_byte(input int sel, input logic [7:0] b);
      @(negedge clk_sys);
      case (sel)
         0: begin ia.rx_byte = b; ia.rx_vld = 1'b1; end
         1: begin ib.rx_byte = b; ib.rx_vld = 1'b1; end
         default: begin ic.rx_byte = b; ic.rx_vld = 1'b1; end
      endcase
      @(negedge clk_sys);
      ia.rx_vld = 1'b0;
      ib.rx_vld = 1'b0;
      ic.rx_vld = 1'b0;
   endtask

   task automatic reset_checks();
      check("rst_wr_en",      ia.wr_en,      0);
      check("rst_wr_addr",    ia.wr_addr,    0);
      check("rst_wr_data",    ia.wr_data,    0);
      check("rst_wr_bank",    ia.wr_bank,    0);
      check("rst_swap_req",   ia.swap_req,   0);
      check("rst_frame_err",  ia.frame_err,  0);
      check("rst_err_code",   ia.err_code,   0);
      check("rst_busy",       ia.busy,       0);
      check("rst_frames_ok",  ia.frames_ok,  0);
      check("rst_frames_bad", ia.frames_bad, 0);
   endtask

   // Full frame on dut_a; write_buf_sys flips right after the header to prove latching.
   task automatic frame_a(input logic [7:0] csum, input logic bank, input logic good);
      ia.write_buf_sys = bank;
      send_byte(0, 8'hA5);
      send_byte(0, 8'h5A);
      check("busy_hdr", ia.busy, 1);
      ia.write_buf_sys = ~bank;
      for (int k = 0; k < 8; k++) begin
         send_byte(0, pay_a[2*k]);
         check("wr_en_gap", ia.wr_en, 0);
         send_byte(0, pay_a[2*k+1]);
         check("wr_en",   ia.wr_en,   1);
         check("wr_addr", ia.wr_addr, k);
         check("wr_data", ia.wr_data, pix_a[k]);
         check("wr_bank", ia.wr_bank, bank);
      end
      send_byte(0, csum);
      if (good) exp_ok = exp_ok + 16'd1;
      else      exp_bad = exp_bad + 16'd1;
      check("swap_req",  ia.swap_req,  good);
      check("frame_err", ia.frame_err, !good);
      if (!good) check("err_code_csum", ia.err_code, 2'b01);
      check("frames_ok",  ia.frames_ok,  exp_ok);
      check("frames_bad", ia.frames_bad, exp_bad);
      check("busy_end",   ia.busy,       0);
      @(negedge clk_sys);
      check("swap_pulse", ia.swap_req,  0);
      check("err_pulse",  ia.frame_err, 0);
   endtask

   initial begin
      ia.rx_byte = '0; ia.rx_vld = 1'b0; ia.write_buf_sys = 1'b0;
      ib.rx_byte = '0; ib.rx_vld = 1'b0; ib.write_buf_sys = 1'b0;
      ic.rx_byte = '0; ic.rx_vld = 1'b0; ic.write_buf_sys = 1'b0;
      repeat (3) @(negedge clk_sys);
      reset_checks();
      rst_sys = 1'b0;

      // Good frame, then the same frame with a corrupted checksum.
      frame_a(8'hBC, 1'b0, 1'b1);
      frame_a(8'hBD, 1'b0, 1'b0);

      // Garbage before the header: sync must lock on the second A5.
      send_byte(0, 8'h00);
      send_byte(0, 8'hA5);
      check("busy_hunt", ia.busy, 0);
      frame_a(8'hBC, 1'b1, 1'b1);

      // Stall after 5 payload bytes: error after the 50th idle cycle.
      send_byte(0, 8'hA5);
      send_byte(0, 8'h5A);
      for (int i = 0; i < 5; i++) send_byte(0, pay_a[i]);
      repeat (49) @(posedge clk_sys);
      #1;
      check("to_early_err",  ia.frame_err, 0);
      check("to_early_busy", ia.busy,      1);
      @(posedge clk_sys);
      #1;
      exp_bad = exp_bad + 16'd1;
      check("to_err",      ia.frame_err,  1);
      check("to_err_code", ia.err_code,   2'b10);
      check("to_busy",     ia.busy,       0);
      check("to_bad",      ia.frames_bad, exp_bad);
      @(posedge clk_sys);
      #1;
      check("to_pulse", ia.frame_err, 0);
      frame_a(8'hBC, 1'b0, 1'b1);

      // Byte arriving exactly on the terminal count keeps the frame alive.
      send_byte(0, 8'hA5);
      send_byte(0, 8'h5A);
      send_byte(0, pay_a[0]);
      repeat (49) @(posedge clk_sys);
      send_byte(0, pay_a[1]);
      check("tc_no_err", ia.frame_err, 0);
      check("tc_busy",   ia.busy,      1);
      check("tc_wr_en",  ia.wr_en,     1);
      check("tc_wr_data", ia.wr_data,  12'hABC);
      repeat (49) @(posedge clk_sys);
      #1;
      check("tc_late_err", ia.frame_err, 0);
      @(posedge clk_sys);
      #1;
      exp_bad = exp_bad + 16'd1;
      check("tc_err",      ia.frame_err,  1);
      check("tc_err_code", ia.err_code,   2'b10);
      check("tc_bad",      ia.frames_bad, exp_bad);

      // Header stall in HUNT1 returns to HUNT0 silently; a lone 5A then must not start a frame.
      send_byte(0, 8'hA5);
      repeat (60) @(posedge clk_sys);
      #1;
      check("h1_no_err", ia.frame_err,  0);
      check("h1_bad",    ia.frames_bad, exp_bad);
      send_byte(0, 8'h5A);
      check("h1_hunt0", ia.busy, 0);

      // Reset mid-payload.
      ia.write_buf_sys = 1'b1;
      send_byte(0, 8'hA5);
      send_byte(0, 8'h5A);
      for (int i = 0; i < 4; i++) send_byte(0, pay_a[i]);
      check("pre_rst_addr", ia.wr_addr, 1);
      check("pre_rst_bank", ia.wr_bank, 1);
      #2 rst_sys = 1'b1;
      #1;
      reset_checks();
      @(negedge clk_sys);
      rst_sys = 1'b0;
      exp_ok  = '0;
      exp_bad = '0;
      frame_a(8'hBC, 1'b0, 1'b1);

      // 24-bit pixels: 12 34 56 / AB CD EF, checksum 0x03.
      send_byte(1, 8'hA5);
      send_byte(1, 8'h5A);
      send_byte(1, 8'h12);
      check("b_gap0", ib.wr_en, 0);
      send_byte(1, 8'h34);
      check("b_gap1", ib.wr_en, 0);
      send_byte(1, 8'h56);
      check("b_wr_en0",  ib.wr_en,   1);
      check("b_addr0",   ib.wr_addr, 0);
      check("b_data0",   ib.wr_data, 24'h123456);
      send_byte(1, 8'hAB);
      send_byte(1, 8'hCD);
      send_byte(1, 8'hEF);
      check("b_addr1",   ib.wr_addr, 1);
      check("b_data1",   ib.wr_data, 24'hABCDEF);
      send_byte(1, 8'h03);
      check("b_swap",    ib.swap_req,  1);
      check("b_ok",      ib.frames_ok, 1);

      // 5-bit pixels: F8 -> 1F, 0F -> 01, checksum 0x07.
      send_byte(2, 8'hA5);
      send_byte(2, 8'h5A);
      send_byte(2, 8'hF8);
      check("c_wr_en0", ic.wr_en,   1);
      check("c_data0",  ic.wr_data, 5'h1F);
      send_byte(2, 8'h0F);
      check("c_addr1",  ic.wr_addr, 1);
      check("c_data1",  ic.wr_data, 5'h01);
      send_byte(2, 8'h07);
      check("c_swap",   ic.swap_req,  1);
      check("c_ok",     ic.frames_ok, 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/uart_frame_loader_sync.md
# uart_frame_loader_sync

Parametrised UART-to-framebuffer loader with frame sync, integrity check and timeout recovery. Consumes a byte stream from the UART RX core in the system domain, hunts for a 2-byte sync header, writes WIDTH×HEIGHT pixels of PIX_BITS each into the inactive bank of the dual-buffered image store, and verifies an 8-bit checksum. A buffer swap is requested only for frames that pass the check; malformed or stalled frames are discarded and the block re-synchronises on the next header.

## Interface
- WIDTH, 320, pixels per line
- HEIGHT, 240, lines per frame
- PIX_BITS, 12, bits per pixel (1..24)
- ADDR_W, 17, write-address width; must satisfy 2^ADDR_W ≥ WIDTH*HEIGHT
- SYNC0, 8'hA5, first header byte
- SYNC1, 8'h5A, second header byte
- TIMEOUT_CYC, 1000000, max clk_sys cycles between accepted bytes inside a frame
- clk_sys  in  1  system clock
- rst_sys  in  1  reset rst_sys, asynchronous, active-high
- rx_byte  in  8  received byte
- rx_vld  in  1  1-cycle strobe, rx_byte valid
- write_buf_sys  in  1  currently inactive bank, from the dual buffer
- wr_en  out  1  pixel write strobe
- wr_addr  out  ADDR_W  pixel address, 0..WIDTH*HEIGHT-1, raster order
- wr_data  out  PIX_BITS  pixel value
- wr_bank  out  1  bank latched at frame start
- swap_req  out  1  1-cycle pulse, good frame complete
- frame_err  out  1  1-cycle pulse, frame discarded
- err_code  out  2  cause of last frame_err: 01 checksum, 10 timeout
- busy  out  1  high from header accept until frame end/abort
- frames_ok  out  16  count of good frames, wraps
- frames_bad  out  16  count of discarded frames, wraps

## Operation
- Derived: BPP = (PIX_BITS+7)/8 bytes per pixel; NPIX = WIDTH*HEIGHT.
- Frame format: SYNC0, SYNC1, NPIX×BPP payload bytes (MSB byte first), 1 checksum byte = sum of all payload bytes mod 256. Header not included in the sum.
- Pixel assembly: BPP bytes concatenated MSB-first into an 8*BPP-bit word; wr_data = top PIX_BITS bits (left-justified; unused low bits ignored). PIX_BITS=12 → byte0=rgb[11:4], byte1[7:4]=rgb[3:0].
- States (only bytes with rx_vld=1 advance):
  - HUNT0: byte==SYNC0 → HUNT1; else stay.
  - HUNT1: byte==SYNC1 → PAYLOAD, clear pixel addr, byte index, checksum, latch wr_bank←write_buf_sys, busy←1; byte==SYNC0 → stay HUNT1; else → HUNT0.
  - PAYLOAD: add byte to checksum, shift into assembly register; on byte index BPP-1 issue write at current addr, increment addr, reset index. After write at addr NPIX-1 → CSUM.
  - CSUM: byte==checksum → swap_req, frames_ok+1; else frame_err, err_code←01, frames_bad+1. Both → HUNT0, busy←0.
- Timeout: idle counter cleared on every rx_vld and on entering HUNT0; counts only in HUNT1/PAYLOAD/CSUM. On reaching TIMEOUT_CYC-1: → HUNT0, frame_err, err_code←10, frames_bad+1 only if state was PAYLOAD/CSUM (HUNT1 timeout silently returns to HUNT0).
- Discarded frames leave partially written pixels in the inactive bank; no swap issued, so they are never displayed.
- Payload bytes equal to SYNC0/SYNC1 are data; no re-sync mid-frame except via timeout.

## Timing
- All outputs registered. Reset: wr_en=0, wr_addr=0, wr_data=0, wr_bank=0, swap_req=0, frame_err=0, err_code=00, busy=0, frames_ok=0, frames_bad=0, state HUNT0.
- wr_en/wr_addr/wr_data/wr_bank valid the cycle after the rx_vld of the pixel's last byte; wr_en high exactly one cycle.
- swap_req/frame_err one cycle after the checksum rx_vld, or one cycle after the timeout terminal count; never simultaneous.
- rx_vld coincident with timeout terminal count: byte wins, counter clears, no error.
- Back-to-back rx_vld on consecutive cycles supported; min 1-cycle spacing.
- Reset mid-frame: immediate abort, no swap, no counter change beyond reset values.

## Test plan
- WIDTH=4, HEIGHT=2, PIX_BITS=12: send A5 5A, 16 payload bytes, correct checksum → 8 writes addr 0..7, pixel 0 from bytes AB,C0 = 12'hABC, swap_req once, frames_ok=1.
- Same frame with checksum+1 → 8 writes, no swap_req, frame_err with err_code=01, frames_bad=1.
- Garbage 00 A5 A5 5A then valid frame → sync found on second A5, frame accepted normally.
- TIMEOUT_CYC=50, stop after 5 payload bytes → frame_err err_code=10 at 50th idle cycle, busy=0; next valid frame accepted with addr restarting at 0.
- PIX_BITS=24, BPP=3: bytes 12 34 56 per pixel → wr_data=24'h123456; PIX_BITS=5: byte F8 → wr_data=5'h1F.
- write_buf_sys toggled mid-frame → wr_bank holds value latched at SYNC1; rst_sys asserted mid-payload → all outputs at reset values next cycle, no swap_req.
